trace_record_assembler: RTL and testbench
=========================================

TRACE_RECORD_ASSEMBLER -- requirements
Module: trace_record_assembler

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 32, instruction address width.
REQ-003 Parameter TIME_WIDTH, default 32, timestamp width.
REQ-004 Parameter DEPTH, default 4, in-flight record slots; power of two, 2..16.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 if_start_i  in  1  fetch begins; allocates slot. if_addr_i  in  ADDR_WIDTH  fetch address. if_pass_i  in  1  pass-through flag.
REQ-008 if_end_i  in  1  fetch done. if_instr_i  in  DATA_WIDTH  fetched instruction.
REQ-009 id_start_i, id_end_i, ex_start_i, ex_end_i, wb_start_i, wb_end_i  in  1 each  stage boundary strobes.
REQ-010 out_valid_o  out  1; out_ready_i  in  1; out_instr_o  out  DATA_WIDTH; out_addr_o  out  ADDR_WIDTH; out_pass_o  out  1; out_times_o  out  8*TIME_WIDTH, {IF,ID,EX,WB} x {start,end}, IF start in MSBs.
REQ-011 overflow_o  out  1  sticky slot-overflow flag; drop_cnt_o  out  8  saturating dropped-fetch count.

Function
REQ-012 Free-running timestamp counter SHALL increment each cycle, wrap 2^TIME_WIDTH-1 -> 0.
REQ-013 Every strobe SHALL record the counter value of the cycle in which it is high.
REQ-014 Slots SHALL form a circular buffer; per-stage pointers (IF, ID, EX, WB, OUT) each wrap DEPTH-1 -> 0.
REQ-015 if_start_i SHALL write addr, pass flag, IF start into slot at alloc pointer and advance it, unless all DEPTH slots are occupied.
REQ-016 if_start_i with buffer full SHALL be dropped: no slot written, overflow_o set, drop_cnt_o +1 saturating at 255; the matching later strobes of that instruction are ignored via a per-stage skip count.
REQ-017 Each *_end_i SHALL write its end time at that stage's pointer and advance it; *_start_i writes start time without advancing; if_end_i also writes instruction.
REQ-018 A strobe targeting a slot not yet allocated SHALL be ignored.
REQ-019 Slot SHALL be complete when wb_end recorded; out_valid_o SHALL assert the cycle after wb_end_i for the head slot (latency 1).
REQ-020 Records SHALL be emitted strictly in allocation order.
REQ-021 out_* SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-022 Handshake (valid&ready) SHALL free head slot and advance OUT pointer; next complete slot presented the following cycle (1 record/cycle max).
REQ-023 Same-cycle free and if_start_i with buffer full SHALL accept the fetch (freed slot counts).
REQ-024 Start and end strobes of one stage in the same cycle SHALL both record the same timestamp.

Reset
REQ-025 With rst high at a clock edge: counter=0, all pointers=0, occupancy=0, out_valid_o=0, out_* data=0, overflow_o=0, drop_cnt_o=0.
REQ-026 Reset mid-operation SHALL discard all in-flight records without emitting them; strobes during rst ignored.

Structure
REQ-027 Trace record struct, per-stage timing struct and stage-index enum SHALL live in ryuki_datatypes, widths via `DATA_WIDTH/`ADDR_WIDTH defines; TIME_WIDTH default as package constant.
REQ-028 Timestamp counter SHALL be sub-module trace_timestamp_counter (TIME_WIDTH parameter, clk, rst, count output).
REQ-029 Slot storage SHALL be flops (no RAM inference required).

Verification
REQ-030 Reset, one instruction: if_start t=2 addr 0x100, if_end t=3 instr 0x00A00093, ID 4-5, EX 6-7, WB 8-9, ready=1 -> out_valid at t=10, times {2,3,4,5,6,7,8,9}.
REQ-031 DEPTH=4, 5 back-to-back if_start, no retirement -> 4 accepted, overflow_o=1, drop_cnt_o=1; 5th never emitted.
REQ-032 Three records complete, out_ready low 5 cycles -> out_* stable; then ready=1 -> 3 records in 3 consecutive cycles, order addr 0x100,0x104,0x108.
REQ-033 TIME_WIDTH=4, if_start at counter 14, wb_end at counter 3 -> recorded values 14 and 3 (wrap).
REQ-034 rst asserted with 2 records pending -> no emission, out_valid_o=0 next cycle, next record from slot 0 with timestamps from 0.
REQ-035 Buffer full, handshake and if_start same cycle -> fetch accepted, drop_cnt_o unchanged.

Source files
------------

// File: rtl/ryuki_datatypes.sv
// Shared trace types: pipeline stage index, per-stage timing pair and the assembled record.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package ryuki_datatypes;

  localparam int TIME_WIDTH_DEF = 32;
  localparam int NUM_STAGES     = 4;

  typedef enum logic [1:0] {
    STG_IF = 2'd0,
    STG_ID = 2'd1,
    STG_EX = 2'd2,
    STG_WB = 2'd3
  } stage_e;

  typedef struct packed {
    logic [TIME_WIDTH_DEF-1:0] start_t;
    logic [TIME_WIDTH_DEF-1:0] end_t;
  } stage_time_t;

  typedef struct packed {
    logic [`DATA_WIDTH-1:0]        instr;
    logic [`ADDR_WIDTH-1:0]        addr;
    logic                          pass;
    stage_time_t [NUM_STAGES-1:0]  times;
  } trace_rec_t;

endpackage

// File: rtl/trace_timestamp_counter.sv
// Free-running timestamp source; wraps naturally at 2^TIME_WIDTH.
module trace_timestamp_counter
  import ryuki_datatypes::*;
#(
  parameter int TIME_WIDTH = TIME_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [TIME_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count + TIME_WIDTH'(1);
  end

endmodule

// File: rtl/trace_record_assembler.sv
// Collects per-stage timestamps of in-flight instructions into a circular slot buffer
// and emits completed trace records in allocation order through a valid/ready port.
module trace_record_assembler
  import ryuki_datatypes::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int TIME_WIDTH = TIME_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_start_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_pass_i,
  input  logic                    if_end_i,
  input  logic [DATA_WIDTH-1:0]   if_instr_i,
  input  logic                    id_start_i,
  input  logic                    id_end_i,
  input  logic                    ex_start_i,
  input  logic                    ex_end_i,
  input  logic                    wb_start_i,
  input  logic                    wb_end_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_instr_o,
  output logic [ADDR_WIDTH-1:0]   out_addr_o,
  output logic                    out_pass_o,
  output logic [8*TIME_WIDTH-1:0] out_times_o,
  output logic                    overflow_o,
  output logic [7:0]              drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [TIME_WIDTH-1:0] now;

  trace_timestamp_counter #(.TIME_WIDTH(TIME_WIDTH)) u_ts (
    .clk  (clk),
    .rst  (rst),
    .count(now)
  );

  // IF start is taken by allocation itself, so its slot in the start vector stays idle.
  logic [NUM_STAGES-1:0] st_start, st_end;
  assign st_start = {wb_start_i, ex_start_i, id_start_i, 1'b0};
  assign st_end   = {wb_end_i, ex_end_i, id_end_i, if_end_i};

  logic [PW-1:0] alloc_ptr, out_ptr;
  logic [PW-1:0] stg_ptr    [NUM_STAGES];
  logic [CW-1:0] occ;
  logic [CW-1:0] pend       [NUM_STAGES];
  logic [CW-1:0] skip_after [NUM_STAGES];
  logic [7:0]    skip       [NUM_STAGES];

  logic                  handshake, full, alloc_ok, drop;
  logic [NUM_STAGES-1:0] skipping, tgt_ok, wr_start, wr_end, eat_end;

  // A stage skips a dropped fetch only once every older accepted record has passed it.
  always_comb begin
    handshake = out_valid_o & out_ready_i;
    full      = (occ == FULL);
    alloc_ok  = if_start_i & (~full | handshake);
    drop      = if_start_i & full & ~handshake;
    for (int s = 0; s < NUM_STAGES; s++) begin
      skipping[s] = (skip[s] != 8'd0) && (skip_after[s] == '0);
      tgt_ok[s]   = ~skipping[s] & ((pend[s] != '0) | alloc_ok);
      wr_start[s] = st_start[s] & tgt_ok[s];
      wr_end[s]   = st_end[s] & tgt_ok[s];
      eat_end[s]  = st_end[s] & skipping[s];
    end
  end

  // Head is complete when some occupied slot has already passed WB.
  assign out_valid_o = (occ != pend[STG_WB]);

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr  <= '0;
      out_ptr    <= '0;
      occ        <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= 8'd0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        stg_ptr[s]    <= '0;
        pend[s]       <= '0;
        skip[s]       <= 8'd0;
        skip_after[s] <= '0;
      end
    end else begin
      if (alloc_ok)  alloc_ptr <= alloc_ptr + PW'(1);
      if (handshake) out_ptr   <= out_ptr + PW'(1);
      occ <= occ + CW'(alloc_ok) - CW'(handshake);
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
      end
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (wr_end[s]) stg_ptr[s] <= stg_ptr[s] + PW'(1);
        pend[s] <= pend[s] + CW'(alloc_ok) - CW'(wr_end[s]);
        if (drop && !eat_end[s] && skip[s] != 8'hFF) skip[s] <= skip[s] + 8'd1;
        else if (!drop && eat_end[s])                skip[s] <= skip[s] - 8'd1;
        if (drop && skip[s] == 8'd0)
          skip_after[s] <= pend[s] - CW'(wr_end[s]);
        else if (wr_end[s] && skip_after[s] != '0)
          skip_after[s] <= skip_after[s] - CW'(1);
      end
    end
  end

  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [DEPTH-1:0]      pass_q;
  logic [TIME_WIDTH-1:0] t_start [DEPTH][NUM_STAGES];
  logic [TIME_WIDTH-1:0] t_end   [DEPTH][NUM_STAGES];

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      addr_q[alloc_ptr]          <= if_addr_i;
      pass_q[alloc_ptr]          <= if_pass_i;
      t_start[alloc_ptr][STG_IF] <= now;
    end
    if (wr_end[STG_IF]) instr_q[stg_ptr[STG_IF]] <= if_instr_i;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (wr_start[s]) t_start[stg_ptr[s]][s] <= now;
      if (wr_end[s])   t_end[stg_ptr[s]][s]   <= now;
    end
  end

  // Record fields read straight from the head slot; the slot cannot change while it is the head.
  always_comb begin
    out_instr_o = '0;
    out_addr_o  = '0;
    out_pass_o  = 1'b0;
    out_times_o = '0;
    if (out_valid_o) begin
      out_instr_o = instr_q[out_ptr];
      out_addr_o  = addr_q[out_ptr];
      out_pass_o  = pass_q[out_ptr];
      for (int s = 0; s < NUM_STAGES; s++) begin
        out_times_o[(2*(NUM_STAGES-1-s)+1)*TIME_WIDTH +: TIME_WIDTH] = t_start[out_ptr][s];
        out_times_o[(2*(NUM_STAGES-1-s))*TIME_WIDTH +: TIME_WIDTH]   = t_end[out_ptr][s];
      end
    end
  end

endmodule

// File: tb/tb_trace_record_assembler.sv
// Bench for trace_record_assembler: directed scenarios plus a randomized instruction stream
// checked against a record-level scoreboard.
module tb_trace_record_assembler;

  localparam int DW = 32, AW = 32, TW = 32, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic if_start, if_pass, if_end, id_start, id_end, ex_start, ex_end, wb_start, wb_end, out_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_instr;
  logic out_valid, out_pass, overflow;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_addr;
  logic [8*TW-1:0] out_times;
  logic [7:0] drop_cnt;

  logic b_if_start, b_if_pass, b_if_end, b_id_start, b_id_end, b_ex_start, b_ex_end;
  logic b_wb_start, b_wb_end, b_out_ready;
  logic [AW-1:0] b_if_addr;
  logic [DW-1:0] b_if_instr;
  logic b_out_valid, b_out_pass, b_overflow;
  logic [DW-1:0] b_out_instr;
  logic [AW-1:0] b_out_addr;
  logic [31:0] b_out_times;
  logic [7:0] b_drop_cnt;

  trace_record_assembler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIME_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_start_i(if_start), .if_addr_i(if_addr), .if_pass_i(if_pass),
    .if_end_i(if_end), .if_instr_i(if_instr),
    .id_start_i(id_start), .id_end_i(id_end), .ex_start_i(ex_start), .ex_end_i(ex_end),
    .wb_start_i(wb_start), .wb_end_i(wb_end),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
    .out_addr_o(out_addr), .out_pass_o(out_pass), .out_times_o(out_times),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  trace_record_assembler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIME_WIDTH(4), .DEPTH(DEPTH)) dut_w4 (
    .clk(clk), .rst(rst),
    .if_start_i(b_if_start), .if_addr_i(b_if_addr), .if_pass_i(b_if_pass),
    .if_end_i(b_if_end), .if_instr_i(b_if_instr),
    .id_start_i(b_id_start), .id_end_i(b_id_end), .ex_start_i(b_ex_start), .ex_end_i(b_ex_end),
    .wb_start_i(b_wb_start), .wb_end_i(b_wb_end),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_instr_o(b_out_instr),
    .out_addr_o(b_out_addr), .out_pass_o(b_out_pass), .out_times_o(b_out_times),
    .overflow_o(b_overflow), .drop_cnt_o(b_drop_cnt)
  );

  int errors = 0;
  int checks = 0;
  int ts = 0;

  // Scoreboard: per-instruction attributes and IF-start cycle; queue of accepted, unemitted ids.
  int          S [32];
  logic [31:0] A [32];
  logic [31:0] I [32];
  bit          P [32];
  int          q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ts++;
  endtask

  task automatic clr();
    if_start = 0; if_end = 0; id_start = 0; id_end = 0;
    ex_start = 0; ex_end = 0; wb_start = 0; wb_end = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ts = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_times", out_times, 0);
    chk("rst_valid_w4", b_out_valid, 0);
  endtask

  function automatic logic [255:0] exp_times(input int s0);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[(7-k)*32 +: 32] = 32'(s0 + k);
    return r;
  endfunction

  task automatic set_instr(input int i, input int s0, input logic [31:0] a,
                           input logic [31:0] ins, input bit p);
    S[i] = s0; A[i] = a; I[i] = ins; P[i] = p;
  endtask

  // Each instruction spends two cycles per stage: start at IF start + 2k, end one cycle later.
  task automatic run(input int n, input bit dyn, input int rlo, input int rhi, input int stop_at);
    int started = 0;
    int last = -10;
    int cyc = 0;
    int d;
    bit elig, hs, go;
    q.delete();
    while ((started < n || q.size() > 0) && ts != stop_at) begin
      if (ts >= rlo && ts <= rhi) out_ready = 1'b0;
      else out_ready = dyn ? ($urandom_range(3) != 0) : 1'b1;
      elig = 1'b0;
      if (q.size() > 0) elig = (ts >= S[q[0]] + 8);
      chk("out_valid", out_valid, elig);
      if (elig) begin
        chk("out_instr", out_instr, I[q[0]]);
        chk("out_addr", out_addr, A[q[0]]);
        chk("out_pass", out_pass, P[q[0]]);
        chk("out_times", out_times, exp_times(S[q[0]]));
      end
      hs = elig && out_ready;
      if (hs) void'(q.pop_front());
      if (started < n) begin
        if (dyn) go = (ts >= last + 2) && ($urandom_range(1) == 1) && (q.size() < DEPTH);
        else     go = (ts == S[started]);
        if (go) begin
          if (dyn) S[started] = ts;
          q.push_back(started);
          last = ts;
          started++;
        end
      end
      clr();
      for (int i = 0; i < started; i++) begin
        d = ts - S[i];
        case (d)
          0: begin if_start = 1; if_addr = A[i]; if_pass = P[i]; end
          1: begin if_end = 1; if_instr = I[i]; end
          2: id_start = 1;
          3: id_end = 1;
          4: ex_start = 1;
          5: ex_end = 1;
          6: wb_start = 1;
          7: wb_end = 1;
          default: ;
        endcase
      end
      step();
      cyc++;
      if (cyc > 3000) begin
        checks++;
        errors++;
        $error("FAIL engine_timeout: observed=%0d cycles expected<=3000", cyc);
        break;
      end
    end
    clr();
    chk("run_overflow", overflow, 0);
    chk("run_drop", drop_cnt, 0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; if_addr = '0; if_instr = '0; if_pass = 0;
    clr();
    b_if_start = 0; b_if_end = 0; b_id_start = 0; b_id_end = 0; b_ex_start = 0; b_ex_end = 0;
    b_wb_start = 0; b_wb_end = 0; b_out_ready = 1; b_if_addr = '0; b_if_instr = '0; b_if_pass = 0;

    do_reset();

    // 4-bit timestamps: IF start at 14, WB end at 3 after wrapping; ID and EX start/end coincide.
    while (ts < 14) step();
    b_if_start = 1; b_if_addr = 32'h300; b_if_pass = 1;
    step();
    b_if_start = 0; b_if_end = 1; b_if_instr = 32'h1234_5678;
    step();
    b_if_end = 0; b_id_start = 1; b_id_end = 1;
    step();
    b_id_start = 0; b_id_end = 0; b_ex_start = 1; b_ex_end = 1;
    step();
    b_ex_start = 0; b_ex_end = 0; b_wb_start = 1;
    step();
    b_wb_start = 0; b_wb_end = 1;
    chk("wrap_not_yet_valid", b_out_valid, 0);
    step();
    b_wb_end = 0;
    chk("wrap_valid", b_out_valid, 1);
    chk("wrap_times", b_out_times, 32'hEF00_1123);
    chk("wrap_addr", b_out_addr, 32'h300);
    chk("wrap_instr", b_out_instr, 32'h1234_5678);
    chk("wrap_pass", b_out_pass, 1);
    step();
    chk("wrap_popped", b_out_valid, 0);

    // Single instruction right after reset.
    do_reset();
    set_instr(0, 2, 32'h100, 32'h00A0_0093, 0);
    run(1, 0, -1, -1, -1);

    // Four records held with ready low, then drained back to back while a fetch lands on the full buffer.
    do_reset();
    for (int i = 0; i < 4; i++) set_instr(i, 2 + 2*i, 32'h100 + 32'(4*i), $urandom, 1'($urandom_range(1)));
    set_instr(4, 21, 32'h110, $urandom, 1);
    run(5, 0, 0, 20, -1);

    // Five back-to-back fetches without retirement: the fifth is dropped.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if_start = 1; if_addr = 32'h200 + 32'(4*k);
      if (k == 4) begin
        chk("ovf_before_drop", overflow, 0);
        chk("drop_before_drop", drop_cnt, 0);
      end
      step();
    end
    clr();
    out_ready = 1;
    chk("ovf_after_drop", overflow, 1);
    chk("drop_after_drop", drop_cnt, 1);
    repeat (10) step();
    chk("ovf_sticky", overflow, 1);
    chk("nothing_emitted", out_valid, 0);

    // Reset with two complete records waiting; they must vanish and numbering restarts.
    do_reset();
    set_instr(0, 2, 32'h400, $urandom, 0);
    set_instr(1, 4, 32'h404, $urandom, 1);
    run(2, 0, 0, 1000, 14);
    do_reset();
    set_instr(0, 2, 32'h500, $urandom, 1);
    run(1, 0, -1, -1, -1);

    // Randomized stream with random back-pressure.
    do_reset();
    for (int i = 0; i < 16; i++) set_instr(i, 0, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(1)));
    run(16, 1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
